lsu_ctrl: RTL and testbench

- Load/store unit between execute and the register-file writeback port.
- Takes the effective address (ALU result), the store data (rs2 read data) and the access size, and runs one data-memory transaction over a valid/ready bus.
- Handles byte-lane placement and write strobes, and returns right-aligned raw load data to the writeback mux (memory-input path).
- Sign/zero extension stays in the register file, driven by the same size code.
- Asserts busy so the core stalls while a transaction is open.

---
 rtl/lsu_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store unit: one data-memory transaction per request over a valid/ready
// bus, with byte-lane placement on stores and right-aligned raw data on loads.

package lsu_ctrl_pkg;
    localparam int unsigned MEM_SIZE_WIDTH = 3;
    localparam logic [MEM_SIZE_WIDTH-1:0] MEM_BYTE   = 3'd0;
    localparam logic [MEM_SIZE_WIDTH-1:0] MEM_HALF   = 3'd1;
    localparam logic [MEM_SIZE_WIDTH-1:0] MEM_WORD   = 3'd2;
    localparam logic [MEM_SIZE_WIDTH-1:0] MEM_BYTE_U = 3'd4;
    localparam logic [MEM_SIZE_WIDTH-1:0] MEM_HALF_U = 3'd5;
endpackage

module lsu_ctrl
    import lsu_ctrl_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [MEM_SIZE_WIDTH-1:0] req_size,
    input  logic [XLEN-1:0]           req_addr,
    input  logic [XLEN-1:0]           req_wdata,
    output logic                      busy,
    output logic                      ld_valid,
    output logic [XLEN-1:0]           ld_data,
    output logic                      st_done,
    output logic                      err_misalign,
    output logic                      err_timeout,
    output logic                      dmem_valid,
    input  logic                      dmem_ready,
    output logic                      dmem_we,
    output logic [XLEN-1:0]           dmem_addr,
    output logic [3:0]                dmem_wstrb,
    output logic [XLEN-1:0]           dmem_wdata,
    input  logic                      dmem_rvalid,
    input  logic [XLEN-1:0]           dmem_rdata
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    // Internal access-width encoding; signed/unsigned codes collapse here.
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        off_q, off_d;
    logic [1:0]        sz_q, sz_d;

    logic              dmem_valid_d, dmem_we_d;
    logic [XLEN-1:0]   dmem_addr_d, dmem_wdata_d;
    logic [3:0]        dmem_wstrb_d;
    logic              ld_valid_d, st_done_d, err_misalign_d, err_timeout_d;
    logic [XLEN-1:0]   ld_data_d;

    logic [1:0]        req_sz;
    logic              misalign;
    logic [3:0]        req_strb;
    logic [XLEN-1:0]   req_rep;
    logic [XLEN-1:0]   rd_shift;
    logic [XLEN-1:0]   rd_aligned;

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);

    // Decode the incoming request: width, alignment, lanes and replicated data.
    always_comb begin
        req_sz   = SZ_W;
        misalign = 1'b0;
        req_strb = 4'b1111;
        req_rep  = req_wdata;
        if (req_size == MEM_BYTE || req_size == MEM_BYTE_U) begin
            req_sz   = SZ_B;
            req_strb = 4'b0001 << req_addr[1:0];
            req_rep  = XLEN'({4{req_wdata[7:0]}});
        end else if (req_size == MEM_HALF || req_size == MEM_HALF_U) begin
            req_sz   = SZ_H;
            misalign = req_addr[0];
            req_strb = 4'b0011 << req_addr[1:0];
            req_rep  = XLEN'({2{req_wdata[15:0]}});
        end else begin
            misalign = (req_addr[1:0] != 2'b00);
        end
    end

    // Right-align the returned word and mask it to the access width.
    always_comb begin
        rd_shift = dmem_rdata >> {off_q, 3'b000};
        case (sz_q)
            SZ_B:    rd_aligned = XLEN'(rd_shift[7:0]);
            SZ_H:    rd_aligned = XLEN'(rd_shift[15:0]);
            default: rd_aligned = rd_shift;
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        off_d          = off_q;
        sz_d           = sz_q;
        dmem_valid_d   = dmem_valid;
        dmem_we_d      = dmem_we;
        dmem_addr_d    = dmem_addr;
        dmem_wstrb_d   = dmem_wstrb;
        dmem_wdata_d   = dmem_wdata;
        ld_data_d      = ld_data;
        ld_valid_d     = 1'b0;
        st_done_d      = 1'b0;
        err_misalign_d = 1'b0;
        err_timeout_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (misalign) begin
                        err_misalign_d = 1'b1;
                    end else begin
                        state_d      = REQ;
                        cnt_d        = '0;
                        off_d        = req_addr[1:0];
                        sz_d         = req_sz;
                        dmem_valid_d = 1'b1;
                        dmem_we_d    = req_we;
                        dmem_addr_d  = {req_addr[XLEN-1:2], 2'b00};
                        dmem_wstrb_d = req_strb;
                        dmem_wdata_d = req_rep;
                    end
                end
            end
            REQ: begin
                if (dmem_ready) begin
                    dmem_valid_d = 1'b0;
                    cnt_d        = cnt_q + CNT_W'(1);
                    if (dmem_we) begin
                        state_d   = DONE;
                        st_done_d = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = IDLE;
                    dmem_valid_d  = 1'b0;
                    err_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT: begin
                if (dmem_rvalid) begin
                    state_d    = DONE;
                    ld_valid_d = 1'b1;
                    ld_data_d  = rd_aligned;
                end else if (cnt_q == CNT_LAST) begin
                    state_d       = IDLE;
                    err_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; synchronous reset drops any open request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            off_q        <= '0;
            sz_q         <= SZ_W;
            dmem_valid   <= 1'b0;
            dmem_we      <= 1'b0;
            dmem_addr    <= '0;
            dmem_wstrb   <= '0;
            dmem_wdata   <= '0;
            ld_data      <= '0;
            ld_valid     <= 1'b0;
            st_done      <= 1'b0;
            err_misalign <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            off_q        <= off_d;
            sz_q         <= sz_d;
            dmem_valid   <= dmem_valid_d;
            dmem_we      <= dmem_we_d;
            dmem_addr    <= dmem_addr_d;
            dmem_wstrb   <= dmem_wstrb_d;
            dmem_wdata   <= dmem_wdata_d;
            ld_data      <= ld_data_d;
            ld_valid     <= ld_valid_d;
            st_done      <= st_done_d;
            err_misalign <= err_misalign_d;
            err_timeout  <= err_timeout_d;
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: stores, loads, misalignment, timeout and reset.

module tb_lsu_ctrl;
    import lsu_ctrl_pkg::*;

    logic                      clk;
    logic                      rst;
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_we;
    logic [MEM_SIZE_WIDTH-1:0] req_size;
    logic [31:0]               req_addr;
    logic [31:0]               req_wdata;
    logic                      busy;
    logic                      ld_valid;
    logic [31:0]               ld_data;
    logic                      st_done;
    logic                      err_misalign;
    logic                      err_timeout;
    logic                      dmem_valid;
    logic                      dmem_ready;
    logic                      dmem_we;
    logic [31:0]               dmem_addr;
    logic [3:0]                dmem_wstrb;
    logic [31:0]               dmem_wdata;
    logic                      dmem_rvalid;
    logic [31:0]               dmem_rdata;

    int total = 0;
    int bad   = 0;

    lsu_ctrl #(.XLEN(32), .TIMEOUT(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .busy         (busy),
        .ld_valid     (ld_valid),
        .ld_data      (ld_data),
        .st_done      (st_done),
        .err_misalign (err_misalign),
        .err_timeout  (err_timeout),
        .dmem_valid   (dmem_valid),
        .dmem_ready   (dmem_ready),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wstrb   (dmem_wstrb),
        .dmem_wdata   (dmem_wdata),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge and settle before sampling or driving.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [MEM_SIZE_WIDTH-1:0] size,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid = 1'b1;
        req_we    = we;
        req_size  = size;
        req_addr  = addr;
        req_wdata = wdata;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = MEM_WORD;
        req_addr = '0; req_wdata = '0; dmem_ready = 1'b0; dmem_rvalid = 1'b0;
        dmem_rdata = '0;
        tick();
        tick();
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dvalid", 32'(dmem_valid), 32'd0);
        chk("rst_wstrb", 32'(dmem_wstrb), 32'h0);
        chk("rst_lddata", ld_data, 32'h0);
        chk("rst_pulses", {28'd0, ld_valid, st_done, err_misalign, err_timeout}, 32'h0);
        rst = 1'b0;
        tick();

        // Store word, ready immediately.
        dmem_ready = 1'b1;
        issue(1'b1, MEM_WORD, 32'h0000_0100, 32'hDEAD_BEEF);
        chk("sw_dvalid", 32'(dmem_valid), 32'd1);
        chk("sw_we", 32'(dmem_we), 32'd1);
        chk("sw_addr", dmem_addr, 32'h0000_0100);
        chk("sw_wstrb", 32'(dmem_wstrb), 32'hF);
        chk("sw_wdata", dmem_wdata, 32'hDEAD_BEEF);
        chk("sw_ready_low", 32'(req_ready), 32'd0);
        chk("sw_no_done_yet", 32'(st_done), 32'd0);
        tick();
        chk("sw_done", 32'(st_done), 32'd1);
        chk("sw_dvalid_drop", 32'(dmem_valid), 32'd0);
        chk("sw_busy_done", 32'(busy), 32'd1);
        tick();
        chk("sw_done_pulse", 32'(st_done), 32'd0);
        chk("sw_idle", 32'(busy), 32'd0);

        // Store byte to lane 3.
        issue(1'b1, MEM_BYTE, 32'h0000_0203, 32'h1234_56A5);
        chk("sb_addr", dmem_addr, 32'h0000_0200);
        chk("sb_wstrb", 32'(dmem_wstrb), 32'h8);
        chk("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
        tick();
        chk("sb_done", 32'(st_done), 32'd1);
        tick();
        chk("sb_idle", 32'(busy), 32'd0);

        // Store half to upper half.
        issue(1'b1, MEM_HALF, 32'h0000_0102, 32'h1234_ABCD);
        chk("sh_wstrb", 32'(dmem_wstrb), 32'hC);
        chk("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
        tick();
        tick();
        chk("sh_idle", 32'(busy), 32'd0);

        // Load half_u with delayed ready and delayed rvalid.
        dmem_ready = 1'b0;
        issue(1'b0, MEM_HALF_U, 32'h0000_0302, 32'h0);
        chk("lh_dvalid", 32'(dmem_valid), 32'd1);
        chk("lh_we", 32'(dmem_we), 32'd0);
        chk("lh_addr", dmem_addr, 32'h0000_0300);
        chk("lh_wstrb", 32'(dmem_wstrb), 32'hC);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("lh_hold_valid", 32'(dmem_valid), 32'd1);
            chk("lh_hold_addr", dmem_addr, 32'h0000_0300);
            chk("lh_hold_wstrb", 32'(dmem_wstrb), 32'hC);
        end
        dmem_ready = 1'b1;
        tick();
        dmem_ready = 1'b0;
        chk("lh_wait_dvalid", 32'(dmem_valid), 32'd0);
        chk("lh_wait_busy", 32'(busy), 32'd1);
        tick();
        chk("lh_wait_noval", 32'(ld_valid), 32'd0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hBEEF_1234;
        tick();
        dmem_rvalid = 1'b0;
        chk("lh_ldvalid", 32'(ld_valid), 32'd1);
        chk("lh_lddata", ld_data, 32'h0000_BEEF);
        tick();
        chk("lh_ldvalid_pulse", 32'(ld_valid), 32'd0);
        chk("lh_idle", 32'(busy), 32'd0);
        chk("lh_hold_data", ld_data, 32'h0000_BEEF);

        // Misaligned word load.
        issue(1'b0, MEM_WORD, 32'h0000_0401, 32'h0);
        chk("mis_err", 32'(err_misalign), 32'd1);
        chk("mis_dvalid", 32'(dmem_valid), 32'd0);
        chk("mis_ready", 32'(req_ready), 32'd1);
        tick();
        chk("mis_err_pulse", 32'(err_misalign), 32'd0);
        chk("mis_dvalid2", 32'(dmem_valid), 32'd0);

        // Timeout with ready held low.
        issue(1'b0, MEM_WORD, 32'h0000_0600, 32'h0);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk("to_busy", 32'(busy), 32'd1);
            chk("to_not_yet", 32'(err_timeout), 32'd0);
        end
        tick();
        chk("to_err", 32'(err_timeout), 32'd1);
        chk("to_idle", 32'(busy), 32'd0);
        chk("to_dvalid", 32'(dmem_valid), 32'd0);
        chk("to_no_ld", 32'(ld_valid), 32'd0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h5555_AAAA;
        tick();
        dmem_rvalid = 1'b0;
        chk("to_late_rvalid", 32'(ld_valid), 32'd0);
        chk("to_err_pulse", 32'(err_timeout), 32'd0);
        chk("to_lddata_hold", ld_data, 32'h0000_BEEF);

        // Reset while in WAIT.
        dmem_ready = 1'b1;
        issue(1'b0, MEM_WORD, 32'h0000_0700, 32'h0);
        dmem_ready = 1'b0;
        tick();
        chk("rw_wait_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rw_busy", 32'(busy), 32'd0);
        chk("rw_ready", 32'(req_ready), 32'd1);
        chk("rw_dvalid", 32'(dmem_valid), 32'd0);
        chk("rw_pulses", {28'd0, ld_valid, st_done, err_misalign, err_timeout}, 32'h0);

        // Fresh load after reset; rvalid during the handshake must be ignored.
        dmem_ready = 1'b1;
        issue(1'b0, MEM_WORD, 32'h0000_0500, 32'h0);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1111_1111;
        tick();
        dmem_ready = 1'b0;
        chk("nl_wait_noval", 32'(ld_valid), 32'd0);
        dmem_rdata = 32'hCAFE_F00D;
        tick();
        dmem_rvalid = 1'b0;
        chk("nl_ldvalid", 32'(ld_valid), 32'd1);
        chk("nl_lddata", ld_data, 32'hCAFE_F00D);
        tick();
        chk("nl_idle", 32'(busy), 32'd0);

        // Byte load from lane 3, upper bits zero.
        dmem_ready = 1'b1;
        issue(1'b0, MEM_BYTE, 32'h0000_0503, 32'h0);
        tick();
        dmem_ready  = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h80AA_BBCC;
        tick();
        dmem_rvalid = 1'b0;
        chk("lb_ldvalid", 32'(ld_valid), 32'd1);
        chk("lb_lddata", ld_data, 32'h0000_0080);
        tick();
        chk("lb_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
